// File: rtl/scalar_alu_mc.sv
// rtl/scalar_alu_mc.sv - handshaked scalar ALU with iterative shift-add multiplier
//
// Holds one operation at a time. Non-multiply ops register their result on the
// accepting edge; MULT iterates MUL_BITS_PER_CYCLE multiplier bits per cycle.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   flush              abort in-flight op, return to IDLE (highest priority)
//   in_valid/in_ready  request handshake
//   rs1, rs2, imm, pc  operands (pc zero-extended to SCALAR_REG_LEN)
//   alu_signal         op class, func_code = {funct7[5], funct3}
//   out_valid/out_ready result handshake
//   result, sign_bits, illegal  registered outputs, qualified by out_valid
`timescale 1ns/1ps
module scalar_alu_mc #(
  parameter int DATA_LEN           = 32,
  parameter int SCALAR_REG_LEN     = 64,
  parameter int MUL_BITS_PER_CYCLE = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SCALAR_REG_LEN-1:0] rs1,
  input  logic [SCALAR_REG_LEN-1:0] rs2,
  input  logic [SCALAR_REG_LEN-1:0] imm,
  input  logic [DATA_LEN-1:0]       pc,
  input  logic [2:0]                alu_signal,
  input  logic [3:0]                func_code,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SCALAR_REG_LEN-1:0] result,
  output logic [1:0]                sign_bits,
  output logic                      illegal
);
  localparam int W   = SCALAR_REG_LEN;
  localparam int B   = MUL_BITS_PER_CYCLE;
  localparam int SHW = $clog2(W);
  localparam int N   = W / B;
  localparam int CW  = $clog2(N + 1);

  localparam logic [2:0] ALU_NOP     = 3'b000;
  localparam logic [2:0] BINARY      = 3'b001;
  localparam logic [2:0] IMM_BINARY  = 3'b010;
  localparam logic [2:0] BRANCH_COND = 3'b011;
  localparam logic [2:0] MEM_ADDR    = 3'b100;
  localparam logic [2:0] PC_BASED    = 3'b101;
  localparam logic [2:0] IMM         = 3'b110;
  localparam logic [2:0] MULT        = 3'b111;

  localparam logic [1:0] ZERO = 2'b00;
  localparam logic [1:0] POS  = 2'b01;
  localparam logic [1:0] NEG  = 2'b10;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   counter;
  logic [W-1:0]    mcand;
  logic [W-1:0]    mplier;
  logic [W-1:0]    acc;
  logic [W-1:0]    step_acc;
  logic [W-1:0]    op_b;
  logic [W-1:0]    alu_res;
  logic            alu_ill;
  logic [3:0]      bop;
  logic [SHW-1:0]  sh;
  logic            accept;

  function automatic logic [1:0] sign_of(input logic [W-1:0] v);
    if (v[W-1])     return NEG;
    else if (v == '0) return ZERO;
    else            return POS;
  endfunction

  assign out_valid = (state == DONE);
  assign in_ready  = !flush && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;

  // Single-cycle datapath, evaluated on the live inputs so the accepting edge
  // captures the result directly.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    op_b    = (alu_signal == IMM_BINARY) ? imm : rs2;
    sh      = op_b[SHW-1:0];
    // Immediate forms ignore funct7[5] except to pick SRAI over SRLI.
    if (alu_signal == IMM_BINARY)
      bop = {(func_code[2:0] == 3'b101) & func_code[3], func_code[2:0]};
    else
      bop = func_code;
    case (alu_signal)
      BINARY, IMM_BINARY: begin
        case (bop)
          4'b0000: alu_res = rs1 + op_b;
          4'b1000: alu_res = rs1 - op_b;
          4'b0001: alu_res = rs1 << sh;
          4'b0010: alu_res = W'($signed(rs1) < $signed(op_b));
          4'b0011: alu_res = W'(rs1 < op_b);
          4'b0100: alu_res = rs1 ^ op_b;
          4'b0101: alu_res = rs1 >> sh;
          4'b1101: alu_res = $signed(rs1) >>> sh;
          4'b0110: alu_res = rs1 | op_b;
          4'b0111: alu_res = rs1 & op_b;
          default: alu_ill = 1'b1;
        endcase
      end
      BRANCH_COND: alu_res = rs1 - rs2;
      MEM_ADDR:    alu_res = rs1 + imm;
      PC_BASED:    alu_res = W'(pc) + imm;
      IMM:         alu_res = imm;
      default:     alu_res = '0;
    endcase
  end

  // One multiplier step: B partial products from the low multiplier bits.
  always_comb begin
    step_acc = acc;
    for (int i = 0; i < B; i++) begin
      if (mplier[i]) step_acc = step_acc + (mcand << i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      result    <= '0;
      sign_bits <= ZERO;
      illegal   <= 1'b0;
      counter   <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        MUL: begin
          // Counter reaching zero marks all steps done; the low half is final.
          if (counter == '0) begin
            result    <= acc;
            sign_bits <= sign_of(acc);
            illegal   <= 1'b0;
            state     <= DONE;
          end else begin
            acc     <= step_acc;
            mcand   <= mcand << B;
            mplier  <= mplier >> B;
            counter <= counter - 1'b1;
          end
        end
        default: begin
          if (accept) begin
            if (alu_signal == MULT) begin
              mcand   <= rs1;
              mplier  <= rs2;
              acc     <= '0;
              counter <= CW'(N);
              state   <= MUL;
            end else begin
              result    <= alu_res;
              sign_bits <= sign_of(alu_res);
              illegal   <= alu_ill;
              state     <= DONE;
            end
          end else if ((state == DONE) && out_ready) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_alu_mc.sv
// tb/tb_scalar_alu_mc.sv - self-checking bench for scalar_alu_mc
`timescale 1ns/1ps
module tb_scalar_alu_mc;
  localparam logic [2:0] NOP = 3'd0, BIN = 3'd1, IMMB = 3'd2, BR = 3'd3;
  localparam logic [2:0] MEM = 3'd4, PCB = 3'd5, IMMV = 3'd6, MULT = 3'd7;
  localparam logic [1:0] S_ZERO = 2'b00, S_POS = 2'b01, S_NEG = 2'b10;
  localparam int MUL_LAT = 64 / 4 + 1;

  logic        clk = 0, rst = 0, flush = 0, in_valid = 0, out_ready = 1;
  logic [63:0] rs1 = 0, rs2 = 0, imm = 0;
  logic [31:0] pc = 0;
  logic [2:0]  alu_signal = 0;
  logic [3:0]  func_code = 0;
  logic        in_ready, out_valid, illegal;
  logic [63:0] result;
  logic [1:0]  sign_bits;

  int total = 0, bad = 0;

  scalar_alu_mc dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .imm(imm), .pc(pc), .alu_signal(alu_signal),
    .func_code(func_code), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .sign_bits(sign_bits), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [64:0] calc(input logic [2:0] s, input logic [3:0] f,
                                       input logic [63:0] a, input logic [63:0] b,
                                       input logic [63:0] im, input logic [31:0] p);
    logic [63:0] y;
    int          amt;
    logic        bad_op;
    y = 0;
    bad_op = 0;
    if (s == BIN || s == IMMB) begin
      logic [63:0] o;
      o   = (s == BIN) ? b : im;
      amt = int'(o % 64);
      case (f[2:0])
        3'd0: begin
          if (s == BIN && f[3]) y = a - o;
          else y = a + o;
          if (s == BIN && f == 4'b1000) y = a - o;
        end
        3'd1: y = a << amt;
        3'd2: y = ($signed(a) < $signed(o)) ? 64'd1 : 64'd0;
        3'd3: y = (a < o) ? 64'd1 : 64'd0;
        3'd4: y = a ^ o;
        3'd5: y = f[3] ? 64'($signed(a) >>> amt) : (a >> amt);
        3'd6: y = a | o;
        3'd7: y = a & o;
      endcase
      // Register-register: only SUB and SRA may carry funct7[5].
      if (s == BIN && f[3] && f != 4'b1000 && f != 4'b1101) begin
        y = 0;
        bad_op = 1;
      end
    end else begin
      case (s)
        BR:      y = a - b;
        MEM:     y = a + im;
        PCB:     y = {32'd0, p} + im;
        IMMV:    y = im;
        MULT:    y = a * b;
        default: y = 0;
      endcase
    end
    return {bad_op, y};
  endfunction

  function automatic logic [1:0] sgn(input logic [63:0] v);
    if ($signed(v) < 0) return S_NEG;
    if (v == 0) return S_ZERO;
    return S_POS;
  endfunction

  logic        m_valid = 0, m_illegal = 0;
  logic [63:0] m_result = 0;
  logic [1:0]  m_sign = S_ZERO;
  logic [64:0] m_pend = 0, m_r = 0;
  int          m_wait = 0;
  logic        m_acc;

  function automatic logic m_ready();
    return !flush && (m_wait == 0) && (!m_valid || out_ready);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0; m_wait = 0; m_result = 0; m_sign = S_ZERO; m_illegal = 0;
    end else begin
      m_acc = in_valid && m_ready();
      if (flush) begin
        m_valid = 0;
        m_wait  = 0;
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          m_result = m_pend[63:0]; m_sign = sgn(m_pend[63:0]); m_illegal = 0; m_valid = 1;
        end
      end else if (m_acc) begin
        m_r = calc(alu_signal, func_code, rs1, rs2, imm, pc);
        if (alu_signal == MULT) begin
          m_pend = m_r; m_wait = MUL_LAT; m_valid = 0;
        end else begin
          m_result = m_r[63:0]; m_sign = sgn(m_r[63:0]); m_illegal = m_r[64]; m_valid = 1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
    end
  end

  // Per-cycle comparison against the model, well away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      chk("cyc_in_ready", in_ready, m_ready());
      chk("cyc_out_valid", out_valid, m_valid);
      chk("cyc_result", result, m_result);
      chk("cyc_sign", sign_bits, m_sign);
      if (m_valid) chk("cyc_illegal", illegal, m_illegal);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic single(input logic [2:0] s, input logic [3:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] im, input logic [31:0] p,
                        input logic [63:0] er, input logic [1:0] es, input logic ei,
                        input string nm);
    @(negedge clk);
    alu_signal = s; func_code = f; rs1 = a; rs2 = b; imm = im; pc = p; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    #3;
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_result"}, result, er);
    chk({nm, "_sign"}, sign_bits, es);
    chk({nm, "_illegal"}, illegal, ei);
    chk({nm, "_model"}, m_result, er);
  endtask

  task automatic mult_test(input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] er, input logic [1:0] es, input string nm);
    int   k;
    logic busy_bad;
    @(negedge clk);
    alu_signal = MULT; func_code = 4'b0101; rs1 = a; rs2 = b; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    rs1 = 64'hDEAD; rs2 = 64'hBEEF;
    k = 0;
    busy_bad = 0;
    #3;
    while (!out_valid && k < 40) begin
      if (in_ready) busy_bad = 1;
      @(negedge clk);
      #3;
      k++;
    end
    chk({nm, "_latency"}, 64'(k), 64'(MUL_LAT));
    chk({nm, "_busy_ready"}, busy_bad, 0);
    chk({nm, "_result"}, result, er);
    chk({nm, "_sign"}, sign_bits, es);
    chk({nm, "_model"}, m_result, er);
  endtask

  initial begin
    int   k;
    logic seen;
    #1 rst = 1;
    @(negedge clk);
    #3;
    chk("reset_result", result, 0);
    chk("reset_sign", sign_bits, S_ZERO);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 0;

    single(BIN, 4'b0000, 64'd5, -64'sd7, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, S_NEG, 0, "add");
    single(BIN, 4'b1000, 64'd7, 64'd7, 0, 0, 64'd0, S_ZERO, 0, "sub");
    single(BIN, 4'b1101, 64'h8000_0000_0000_0000, 64'h43, 0, 0, 64'hF000_0000_0000_0000, S_NEG, 0, "sra");
    single(BIN, 4'b0011, -64'sd1, 64'd1, 0, 0, 64'd0, S_ZERO, 0, "sltu");
    single(BIN, 4'b0010, -64'sd1, 64'd1, 0, 0, 64'd1, S_POS, 0, "slt");
    single(BIN, 4'b0001, 64'd1, 64'h7F, 0, 0, 64'h8000_0000_0000_0000, S_NEG, 0, "sll");
    single(BIN, 4'b0101, 64'hF0, 64'h44, 0, 0, 64'h0F, S_POS, 0, "srl");
    single(BIN, 4'b1001, 64'd3, 64'd4, 0, 0, 64'd0, S_ZERO, 1, "illegal");
    single(IMMB, 4'b1000, 64'd10, 64'd99, 64'd5, 0, 64'd15, S_POS, 0, "addi_b3");
    single(IMMB, 4'b1101, 64'h8000_0000_0000_0000, 0, 64'd4, 0, 64'hF800_0000_0000_0000, S_NEG, 0, "srai");
    single(IMMB, 4'b0101, 64'h8000_0000_0000_0000, 0, 64'd4, 0, 64'h0800_0000_0000_0000, S_POS, 0, "srli");
    single(IMMB, 4'b0110, 64'hF0, 0, 64'h0F, 0, 64'hFF, S_POS, 0, "ori");
    single(BR, 4'b0000, 64'd3, 64'd5, 0, 0, -64'sd2, S_NEG, 0, "branch");
    single(IMMV, 4'b0000, 0, 0, 64'h1234, 0, 64'h1234, S_POS, 0, "imm");
    single(NOP, 4'b0000, 64'd9, 64'd9, 64'd9, 0, 64'd0, S_ZERO, 0, "nop");

    mult_test(64'hFFFF_FFFF, 64'h1_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, S_NEG, "mul_a");
    mult_test(-64'sd3, 64'd5, -64'sd15, S_NEG, "mul_neg");
    mult_test(64'h1_2345_6789, 64'h10, 64'h12_3456_7890, S_POS, "mul_b");

    // Back-to-back issue with out_ready held high, then a stall.
    out_ready = 1;
    @(negedge clk);
    alu_signal = IMMB; func_code = 4'b0000; rs1 = 64'd1; imm = 64'd2; in_valid = 1;
    @(negedge clk);
    alu_signal = MEM; rs1 = 64'h100; imm = 64'h8;
    #3 chk("b2b_addi", result, 64'd3);
    @(negedge clk);
    alu_signal = PCB; pc = 32'h1000; imm = 64'd4;
    #3 chk("b2b_mem", result, 64'h108);
    @(negedge clk);
    in_valid = 0; out_ready = 0;
    #3 chk("b2b_pc", result, 64'h1004);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #3;
      chk("stall_result", result, 64'h1004);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
    end
    @(negedge clk);
    out_ready = 1;

    // Flush in the fifth cycle of a multiply.
    @(negedge clk);
    alu_signal = MULT; rs1 = 64'd3; rs2 = 64'd5; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (4) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    #3;
    chk("flush_in_ready", in_ready, 1);
    chk("flush_result_held", result, 64'h1004);
    seen = 0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      #3;
      if (out_valid) seen = 1;
    end
    chk("flush_no_valid", seen, 0);

    // A request presented together with flush is dropped.
    @(negedge clk);
    alu_signal = IMMV; imm = 64'h55; in_valid = 1; flush = 1;
    #3 chk("flush_blocks_ready", in_ready, 0);
    @(negedge clk);
    in_valid = 0; flush = 0;
    #3 chk("flush_drop_valid", out_valid, 0);

    single(BIN, 4'b0000, 64'd2, 64'd2, 0, 0, 64'd4, S_POS, 0, "add_after_flush");

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    alu_signal = MULT; rs1 = 64'd7; rs2 = 64'd7; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    #1 rst = 1;
    #1;
    chk("arst_result", result, 0);
    chk("arst_sign", sign_bits, S_ZERO);
    chk("arst_valid", out_valid, 0);
    chk("arst_illegal", illegal, 0);
    chk("arst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 0;
    seen = 0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      #3;
      if (out_valid) seen = 1;
    end
    chk("arst_no_output", seen, 0);
    single(MEM, 4'b0000, 64'h200, 0, 64'h10, 0, 64'h210, S_POS, 0, "mem_after_rst");

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
